// File: rtl/prog_run_ctrl.sv
// Program-load and run controller: streams words into IMEM with the core held in reset, then
// runs the core and counts cycles until timeout or halt. Optional halt detection: HALT_DETECT_EN.
module prog_run_ctrl #(
   parameter int unsigned              ADDR_WIDTH = 32,
   parameter int unsigned              DEPTH      = 64,
   parameter logic [ADDR_WIDTH-1:0]    BASE_ADDR  = '0,
   parameter int unsigned              MAX_CYCLES = 1024,
   parameter int unsigned              CNT_WIDTH  = 16,
   localparam int unsigned             WL_WIDTH   = $clog2(DEPTH + 1)
) (
   input  logic                  i_clk,
   input  logic                  i_reset,
   input  logic                  i_start,
   input  logic                  i_abort,
   input  logic                  i_ld_valid,
   input  logic [31:0]           i_ld_data,
   input  logic                  i_ld_last,
   output logic                  o_ld_ready,
   output logic                  o_imem_we,
   output logic [ADDR_WIDTH-1:0] o_imem_addr,
   output logic [31:0]           o_imem_wdata,
   output logic                  o_core_reset,
   input  logic [ADDR_WIDTH-1:0] i_core_pc,
   output logic                  o_busy,
   output logic                  o_done,
   output logic                  o_timeout,
   output logic                  o_halted,
   output logic                  o_load_err,
   output logic [CNT_WIDTH-1:0]  o_cycle_count,
   output logic [WL_WIDTH-1:0]   o_words_loaded
);

   typedef enum logic [1:0] {StIdle, StLoad, StRun, StDone} state_e;

   state_e                r_state;
   logic                  r_we;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [31:0]           r_wdata;
   logic                  r_timeout;
   logic                  r_halted;
   logic                  r_load_err;
   logic [CNT_WIDTH-1:0]  r_cnt;
   logic [WL_WIDTH-1:0]   r_wl;

   logic                  w_ld_ready;
   logic                  w_hs;
   logic                  w_last_slot;
   logic                  w_cnt_max;
   logic                  w_halt;
   logic [ADDR_WIDTH-1:0] w_wr_addr;

   assign w_ld_ready  = (r_state == StLoad) && (r_wl < WL_WIDTH'(DEPTH));
   assign w_hs        = i_ld_valid & w_ld_ready;
   assign w_last_slot = (r_wl == WL_WIDTH'(DEPTH - 1));
   assign w_wr_addr   = BASE_ADDR + (ADDR_WIDTH'(r_wl) << 2);
   assign w_cnt_max   = (r_cnt == CNT_WIDTH'(MAX_CYCLES - 1));

`ifdef HALT_DETECT_EN
   logic [ADDR_WIDTH-1:0] r_pc;
   logic                  r_pc_vld;

   // A PC that repeats on consecutive run cycles means the core sits in a self-loop.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_pc     <= '0;
         r_pc_vld <= 1'b0;
      end else if (r_state == StRun) begin
         r_pc     <= i_core_pc;
         r_pc_vld <= 1'b1;
      end else begin
         r_pc_vld <= 1'b0;
      end
   end

   assign w_halt = (r_state == StRun) && r_pc_vld && (i_core_pc == r_pc);
`else
   logic w_unused_pc;
   assign w_unused_pc = ^i_core_pc;
   assign w_halt      = 1'b0;
`endif

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state    <= StIdle;
         r_we       <= 1'b0;
         r_addr     <= BASE_ADDR;
         r_wdata    <= '0;
         r_timeout  <= 1'b0;
         r_halted   <= 1'b0;
         r_load_err <= 1'b0;
         r_cnt      <= '0;
         r_wl       <= '0;
      end else if (i_abort) begin
         // Counters and status are kept so the aborted run can still be inspected.
         r_state <= StIdle;
         r_we    <= 1'b0;
      end else begin
         r_we <= 1'b0;
         unique case (r_state)
            StIdle, StDone: begin
               if (i_start) begin
                  r_state    <= StLoad;
                  r_cnt      <= '0;
                  r_wl       <= '0;
                  r_timeout  <= 1'b0;
                  r_halted   <= 1'b0;
                  r_load_err <= 1'b0;
               end
            end
            StLoad: begin
               if (w_hs) begin
                  r_we    <= 1'b1;
                  r_addr  <= w_wr_addr;
                  r_wdata <= i_ld_data;
                  r_wl    <= r_wl + WL_WIDTH'(1);
                  if (i_ld_last) begin
                     r_state <= StRun;
                  end else if (w_last_slot) begin
                     r_state    <= StDone;
                     r_load_err <= 1'b1;
                  end
               end
            end
            StRun: begin
               r_cnt <= r_cnt + CNT_WIDTH'(1);
               if (w_halt) r_halted <= 1'b1;
               if (w_cnt_max) r_timeout <= 1'b1;
               if (w_halt || w_cnt_max) r_state <= StDone;
            end
            default: r_state <= StIdle;
         endcase
      end
   end

   assign o_ld_ready     = w_ld_ready;
   assign o_imem_we      = r_we;
   assign o_imem_addr    = r_addr;
   assign o_imem_wdata   = r_wdata;
   assign o_core_reset   = (r_state != StRun);
   assign o_busy         = (r_state == StLoad) || (r_state == StRun);
   assign o_done         = (r_state == StDone);
   assign o_timeout      = r_timeout;
   assign o_halted       = r_halted;
   assign o_load_err     = r_load_err;
   assign o_cycle_count  = r_cnt;
   assign o_words_loaded = r_wl;

endmodule
